// File: rtl/rv32im_bus_arbiter.sv
// rv32im_bus_arbiter
//   Wishbone arbiter and master multiplexer for NUM_MASTERS requesters that
//   share one Wishbone master port. Arbitration is either fixed priority
//   (lowest index wins) or round-robin (first requester after the last
//   winner). An owner keeps the bus until it drops its request, and there is
//   always one idle cycle between owners. ack/err are returned only to the
//   owner.
//
//   Optional build macro RV32IM_BUS_ARB_TIMEOUT_EN: adds a stall watchdog.
//   After TIMEOUT_CYCLES stalled cycles the owner sees a one-cycle err and
//   loses the bus. It cannot win again until it has dropped its request.
//
// Ports
//   clk_i, reset_i        clock (rising edge), asynchronous active-low reset
//   req_i / grant_o       per-master request, one-hot registered grant
//   m_adr_i .. m_we_i     flattened per-master Wishbone outputs (master k at slice k)
//   m_ack_o, m_err_o      slave ack/err returned to the owner only
//   adr_o .. we_o         shared Wishbone master port, all zero when idle
//   ack_i, err_i          slave response
//   busy_o                high while a grant is held
module rv32im_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int XLEN           = 32,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_MASTERS-1:0]        req_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]      m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [XLEN-3:0]               adr_o,
  output logic [XLEN-1:0]               dat_o,
  output logic [3:0]                    sel_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  output logic                          busy_o
);

  localparam int AW = XLEN - 2;
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] req_eff;
  logic                   tmo;
  logic                   grant_legal;
  logic [PW:0]            winner;

  logic [AW-1:0]          own_adr;
  logic [XLEN-1:0]        own_dat;
  logic [3:0]             own_sel;
  logic                   own_cyc, own_stb, own_we;

  // Returns {found, index}. Round-robin scans cyclically starting just after
  // the pointer; fixed mode scans downward so the lowest set index is kept.
  function automatic logic [PW:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                              input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    if (ROUND_ROBIN != 0) begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        j = int'(ptr) + i;
        if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
        if (!found && req[PW'(j)]) begin
          found = 1'b1;
          idx   = PW'(j);
        end
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[PW'(i)]) begin
          found = 1'b1;
          idx   = PW'(i);
        end
      end
    end
    return {found, idx};
  endfunction

  assign grant_legal = ((grant_q & (grant_q - NUM_MASTERS'(1))) == '0);
  assign winner      = pick_winner(req_eff, ptr_q);

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!grant_legal) begin
      // Corrupted (multi-hot) grant: drop to idle and arbitrate afresh.
      grant_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (winner[PW]) begin
            grant_d                = '0;
            grant_d[winner[PW-1:0]] = 1'b1;
            ptr_d                  = winner[PW-1:0];
          end
        end
        default: begin
          // No preemption: only the owner's own request (or a timeout)
          // ends ownership, and the release always passes through idle.
          if (((req_i & grant_q) == '0) || tmo) grant_d = '0;
        end
      endcase
    end
    state_d = (grant_d != '0) ? ST_OWNED : ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // AND-OR mux keyed directly on the registered grant; zero when idle.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        own_adr = own_adr | m_adr_i[k*AW +: AW];
        own_dat = own_dat | m_dat_i[k*XLEN +: XLEN];
        own_sel = own_sel | m_sel_i[k*4 +: 4];
        own_cyc = own_cyc | m_cyc_i[k];
        own_stb = own_stb | m_stb_i[k];
        own_we  = own_we  | m_we_i[k];
      end
    end
  end

  assign adr_o   = own_adr;
  assign dat_o   = own_dat;
  assign sel_o   = own_sel;
  assign we_o    = own_we;
  assign cyc_o   = own_cyc & ~tmo;
  assign stb_o   = own_stb & ~tmo;
  assign grant_o = grant_q;
  assign busy_o  = |grant_q;
  assign m_ack_o = {NUM_MASTERS{ack_i}} & grant_q;
  assign m_err_o = {NUM_MASTERS{err_i | tmo}} & grant_q;

`ifdef RV32IM_BUS_ARB_TIMEOUT_EN
  logic [15:0]            cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   stall;

  // Stall is judged on the owner's raw cyc/stb, not the forced-low outputs.
  assign stall   = own_cyc & own_stb & ~ack_i & ~err_i;
  assign tmo     = stall & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign req_eff = req_i & ~mask_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ack_i || err_i || (grant_d != grant_q)) cnt_d = '0;
    else if (stall)                              cnt_d = cnt_q + 16'd1;
    // A timed-out master stays masked until it is seen with req low.
    mask_d = (mask_q & req_i) | (tmo ? grant_q : '0);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
  assign req_eff        = req_i;
`endif

endmodule
